event_encoder: RTL

EVENT_ENCODER -- requirements
Module: event_encoder

---
 rtl/event_encoder_pkg.sv | 10 +
 rtl/prio_enc8.sv | 29 ++
 rtl/event_encoder.sv | 83 ++++++++
 3 files changed

// File: rtl/event_encoder_pkg.sv
// Shared widths and code type for the event encoder.
// Optional ROUND_ROBIN_EN build selects rotating-priority grant.
package event_encoder_pkg;

  localparam int unsigned REQ_W  = 8;
  localparam int unsigned CODE_W = 3;

  typedef logic [CODE_W-1:0] code_t;

endpackage

// File: rtl/prio_enc8.sv
// Stateless 8-way priority encoder; search starts at ptr and wraps 7->0.
// With ptr tied to 0 this is plain lowest-index-first priority.
module prio_enc8
  import event_encoder_pkg::*;
(
  input  logic [REQ_W-1:0] pending,
  input  code_t            ptr,
  output logic [REQ_W-1:0] grant,
  output code_t            index,
  output logic             any
);

  always_comb begin
    grant = '0;
    index = '0;
    any   = 1'b0;
    for (int i = 0; i < REQ_W; i++) begin
      // 3-bit addition wraps the search window naturally.
      code_t idx;
      idx = ptr + CODE_W'(i);
      if (!any && pending[idx]) begin
        any        = 1'b1;
        index      = idx;
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/event_encoder.sv
// Captures event pulses into a pending set and hands them out one code at a time.
// Define ROUND_ROBIN_EN for rotating priority; otherwise lowest index wins.
module event_encoder
  import event_encoder_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic [REQ_W-1:0] req,
  input  logic             code_ready,
  output code_t            code,
  output logic             code_valid,
  output logic [REQ_W-1:0] pending,
  output logic             overflow
);

  logic [REQ_W-1:0] grant;
  logic [REQ_W-1:0] load_mask;
  code_t            index;
  code_t            ptr_sel;
  logic             any;
  logic             stage_free;
  logic             load;

  assign stage_free = !code_valid || code_ready;
  assign load       = stage_free && any;
  assign load_mask  = load ? grant : '0;

`ifdef ROUND_ROBIN_EN
  code_t ptr;
  logic  xfer;

  assign xfer = code_valid && code_ready;
  // A transfer this edge moves the search start past the code leaving now.
  assign ptr_sel = xfer ? code + CODE_W'(1) : ptr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (xfer) begin
      ptr <= code + CODE_W'(1);
    end
  end
`else
  assign ptr_sel = '0;
`endif

  prio_enc8 u_prio (
    .pending (pending),
    .ptr     (ptr_sel),
    .grant   (grant),
    .index   (index),
    .any     (any)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending    <= '0;
      code       <= '0;
      code_valid <= 1'b0;
      overflow   <= 1'b0;
    end else if (clr) begin
      pending    <= '0;
      code_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      pending <= (pending & ~load_mask) | req;
      // Only a repeat on a bit that stays pending loses an event.
      if (|(req & pending & ~load_mask)) begin
        overflow <= 1'b1;
      end
      if (load) begin
        code       <= index;
        code_valid <= 1'b1;
      end else if (stage_free) begin
        code_valid <= 1'b0;
      end
    end
  end

endmodule
